// File: rtl/game_timer_pkg.sv
// Shared types and constants for the shot-clock countdown controller.
package game_timer_pkg;

  localparam int SEC_W = 7;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  // Binary (0..99) to packed two-digit BCD {tens, ones}.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [SEC_W-1:0] bin);
    logic [BCD_W-1:0] tens_v;
    logic [BCD_W-1:0] ones_v;
    tens_v = BCD_W'(bin / 7'd10);
    ones_v = BCD_W'(bin - (SEC_W'(tens_v) * 7'd10));
    return {tens_v, ones_v};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down-counter that tracks the binary seconds count.
module bcd_down_counter
  import game_timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  // Next digit values: load converts, decrement borrows ones -> tens, 00 holds.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      {tens_d, ones_d} = bin_to_bcd(load_val);
    end else if (dec) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        tens_d = tens_q - 4'd1;
        ones_d = 4'd9;
      end else begin
        tens_d = tens_q;
        ones_d = ones_q;
      end
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// Shot-clock countdown controller: load / run / pause / expire / abort.
// Define GAME_TIMER_BCD_EN to drive tens/ones from a BCD down-counter.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int MAX_SEC  = 99,
  parameter int WARN_SEC = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             stop,
  input  logic             fast_fwd,
  input  logic [SEC_W-1:0] load_val,
  output logic             turbo,
  output logic [SEC_W-1:0] secs_left,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             warning,
  output logic             expired,
  output logic [1:0]       state
);

  timer_state_t     state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [SEC_W-1:0] start_val_s;
  logic             running_q, running_d;
  logic             warning_q, warning_d;
  logic             expired_q, expired_d;
  logic             turbo_q, turbo_d;

  assign start_val_s = (load_val > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : load_val;

  // Next state and count; stop > start > pause/resume > tick.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      secs_d  = start_val_s;
      state_d = (start_val_s == 7'd0) ? ST_EXPIRED : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause && !resume) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (secs_q > 7'd1) begin
              secs_d = secs_q - 7'd1;
            end else begin
              secs_d  = 7'd0;
              state_d = ST_EXPIRED;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (resume && !pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // A zero-value start re-arms the pulse even when already expired.
    expired_d = (state_d == ST_EXPIRED) &&
                ((state_q != ST_EXPIRED) || (start && !stop));
    running_d = (state_d == ST_RUN);
    warning_d = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                (secs_d != 7'd0) && (secs_d <= SEC_W'(WARN_SEC));
    turbo_d   = fast_fwd && (state_q == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      secs_q    <= 7'd0;
      running_q <= 1'b0;
      warning_q <= 1'b0;
      expired_q <= 1'b0;
      turbo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      running_q <= running_d;
      warning_q <= warning_d;
      expired_q <= expired_d;
      turbo_q   <= turbo_d;
    end
  end

  assign state     = state_q;
  assign secs_left = secs_q;
  assign running   = running_q;
  assign warning   = warning_q;
  assign expired   = expired_q;
  assign turbo     = turbo_q;

`ifdef GAME_TIMER_BCD_EN
  logic bcd_load_s;
  logic bcd_dec_s;

  assign bcd_load_s = start && !stop;
  assign bcd_dec_s  = !bcd_load_s && (secs_d < secs_q);

  bcd_down_counter u_bcd (
    .clk      (clk),
    .reset    (reset),
    .load     (bcd_load_s),
    .load_val (start_val_s),
    .dec      (bcd_dec_s),
    .tens     (tens),
    .ones     (ones)
  );
`else
  assign tens = {BCD_W{1'b0}};
  assign ones = {BCD_W{1'b0}};
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Table-driven self-checking bench for game_timer_ctrl with a scoreboard queue.
module tb_game_timer_ctrl;

`ifdef GAME_TIMER_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXP = 2'd3;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, resume, stop, fast_fwd;
  logic [6:0] load_val;
  logic       turbo, running, warning, expired;
  logic [6:0] secs_left;
  logic [3:0] tens, ones;
  logic [1:0] state;

  game_timer_ctrl #(.MAX_SEC(99), .WARN_SEC(5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .resume(resume), .stop(stop), .fast_fwd(fast_fwd), .load_val(load_val),
    .turbo(turbo), .secs_left(secs_left), .tens(tens), .ones(ones),
    .running(running), .warning(warning), .expired(expired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, pa, re, sp, tk, ff;
    logic [6:0] ld;
    logic [1:0] e_state;
    logic [6:0] e_secs;
    logic       e_run, e_warn, e_exp, e_turbo;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic add(input logic rst, st, pa, re, sp, tk, ff, input logic [6:0] ld,
                     input logic [1:0] es, input logic [6:0] esecs,
                     input logic er, ew, ee, et);
    vec_t v;
    v.rst = rst; v.st = st; v.pa = pa; v.re = re; v.sp = sp; v.tk = tk; v.ff = ff;
    v.ld = ld; v.e_state = es; v.e_secs = esecs;
    v.e_run = er; v.e_warn = ew; v.e_exp = ee; v.e_turbo = et;
    vecs.push_back(v);
  endtask

  // Drive one cycle at a negedge, then compare at the following negedge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    reset = v.rst; start = v.st; pause = v.pa; resume = v.re;
    stop = v.sp; tick = v.tk; fast_fwd = v.ff; load_val = v.ld;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".state"},   {6'd0, state},     {6'd0, e.e_state});
    chk({tag, ".secs"},    {1'b0, secs_left}, {1'b0, e.e_secs});
    chk({tag, ".running"}, {7'd0, running},   {7'd0, e.e_run});
    chk({tag, ".warning"}, {7'd0, warning},   {7'd0, e.e_warn});
    chk({tag, ".expired"}, {7'd0, expired},   {7'd0, e.e_exp});
    chk({tag, ".turbo"},   {7'd0, turbo},     {7'd0, e.e_turbo});
    chk({tag, ".tens"},    {4'd0, tens},  BCD_ON ? 8'(e.e_secs / 7'd10) : 8'd0);
    chk({tag, ".ones"},    {4'd0, ones},  BCD_ON ? 8'(e.e_secs % 7'd10) : 8'd0);
  endtask

  initial begin
    vec_t v;
    logic [1:0] m_st;
    logic [6:0] m_secs;
    logic       m_exp;

    reset = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0;
    stop = 1'b0; tick = 1'b0; fast_fwd = 1'b0; load_val = 7'd0;

    //   rst st pa re sp tk ff ld      state   secs  run wrn exp trb
    add(1, 0, 0, 0, 0, 0, 0, 7'd0,   S_IDLE,  7'd0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd3,   S_RUN,   7'd3,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_RUN,   7'd2,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_RUN,   7'd1,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_EXP,   7'd0,  0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7'd0,   S_EXP,   7'd0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_EXP,   7'd0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd12,  S_RUN,   7'd12, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 7'd0,   S_PAUSE, 7'd12, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 0, 1, 0, 7'd0, S_PAUSE, 7'd12, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 7'd0,   S_RUN,   7'd12, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_RUN,   7'd11, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd120, S_RUN,   7'd99, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd10,  S_RUN,   7'd10, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_RUN,   7'd9,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 7'd6,   S_RUN,   7'd6,  1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_RUN,   7'd5,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7'd0,   S_RUN,   7'd5,  1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 7'd0,   S_IDLE,  7'd5,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 7'd0,   S_IDLE,  7'd5,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 7'd0,   S_IDLE,  7'd5,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 7'd8,   S_RUN,   7'd8,  1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 7'd0,   S_RUN,   7'd7,  1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 7'd0,   S_IDLE,  7'd0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7'd0,   S_IDLE,  7'd0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd0,   S_EXP,   7'd0,  0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 7'd0,   S_EXP,   7'd0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 7'd0,   S_IDLE,  7'd0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 7'd0,   S_IDLE,  7'd0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7'd5,   S_RUN,   7'd5,  1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 7'd0,   S_RUN,   7'd5,  1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 7'd0,   S_PAUSE, 7'd5,  0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 7'd0,   S_PAUSE, 7'd5,  0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 7'd0,   S_IDLE,  7'd5,  0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Long countdown with a tick every other cycle, past expiry.
    m_st = S_RUN; m_secs = 7'd12; m_exp = 1'b0;
    v = '{rst:1'b0, st:1'b1, pa:1'b0, re:1'b0, sp:1'b0, tk:1'b0, ff:1'b0, ld:7'd12,
          e_state:S_RUN, e_secs:7'd12, e_run:1'b1, e_warn:1'b0, e_exp:1'b0, e_turbo:1'b0};
    step(v, "cd_load");
    for (int k = 0; k < 30; k++) begin
      v.st = 1'b0; v.ld = 7'd0; v.tk = (k % 2 == 0);
      m_exp = 1'b0;
      if (v.tk && m_st == S_RUN) begin
        if (m_secs > 7'd1) m_secs = m_secs - 7'd1;
        else begin
          m_secs = 7'd0; m_st = S_EXP; m_exp = 1'b1;
        end
      end
      v.e_state = m_st; v.e_secs = m_secs; v.e_run = (m_st == S_RUN);
      v.e_warn = (m_st == S_RUN) && (m_secs != 7'd0) && (m_secs <= 7'd5);
      v.e_exp = m_exp; v.e_turbo = 1'b0;
      step(v, $sformatf("cd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
